// File: rtl/mem_burst_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_burst_arbiter_if
// Description : Requester, abort and memory-side bus bundle for
//               mem_burst_arbiter. The slave modport is the arbiter's view,
//               the master modport is the client/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_burst_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic              we_a;
    logic [DATA_W-1:0] wdata_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic              we_b;
    logic [DATA_W-1:0] wdata_b;
    logic              stop;
    logic              gnt_a;
    logic              gnt_b;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              burst_done;
    logic              aborted;

    modport slave (
        input  req_a, addr_a, we_a, wdata_a,
        input  req_b, addr_b, we_b, wdata_b,
        input  stop,
        output gnt_a, gnt_b, mem_en, mem_we, mem_addr, mem_wdata,
        output busy, burst_done, aborted
    );

    modport master (
        output req_a, addr_a, we_a, wdata_a,
        output req_b, addr_b, we_b, wdata_b,
        output stop,
        input  gnt_a, gnt_b, mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, burst_done, aborted
    );
endinterface
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_burst_arbiter
// Description : Two-requester burst controller. Arbitrates A/B, then issues
//               BURST consecutive (wrapping) memory beats for the winner and
//               pulses burst_done (with aborted) one cycle after the last beat.
//               Optional macro MEM_ARB_RR_EN: round-robin on ties; when it is
//               undefined A has fixed priority over B.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  wire logic          clk,
    input  wire logic          res,
    mem_burst_arbiter_if.slave bus
);

    localparam int               CNT_W     = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [1:0]        req_snap_q, req_snap_d;   // {b, a} captured on IDLE exit
    logic              owner_q,   owner_d;       // 0 = A, 1 = B
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [CNT_W-1:0]  beat_q,    beat_d;
    logic              aborted_q, aborted_d;
    logic              win_b;
`ifdef MEM_ARB_RR_EN
    logic              ptr_q,     ptr_d;         // 0 = A preferred on a tie
`endif

    // State register: all controller flops, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= ST_IDLE;
            req_snap_q <= 2'b00;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            base_q     <= '0;
            beat_q     <= '0;
            aborted_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_snap_q <= req_snap_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            aborted_q  <= aborted_d;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Next-state logic: arbitration from the request snapshot, beat sequencing, abort
    always_comb begin
        state_d    = state_q;
        req_snap_d = req_snap_q;
        owner_d    = owner_q;
        we_d       = we_q;
        base_d     = base_q;
        beat_d     = beat_q;
        aborted_d  = aborted_q;
`ifdef MEM_ARB_RR_EN
        ptr_d      = ptr_q;
        win_b      = req_snap_q[1] & (~req_snap_q[0] | ptr_q);
`else
        win_b      = req_snap_q[1] & ~req_snap_q[0];
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    state_d    = ST_ARB;
                    req_snap_d = {bus.req_b, bus.req_a};
                end
            end
            ST_ARB: begin
                owner_d   = win_b;
                base_d    = win_b ? bus.addr_b : bus.addr_a;
                we_d      = win_b ? bus.we_b : bus.we_a;
                beat_d    = '0;
                aborted_d = 1'b0;
                state_d   = ST_BURST;
            end
            ST_BURST: begin
                beat_d = beat_q + CNT_W'(1);
                if (bus.stop) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
`ifdef MEM_ARB_RR_EN
                ptr_d = ~owner_q;
`endif
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: decoded from registered state; write data muxed live from the owner
    always_comb begin
        bus.gnt_a      = 1'b0;
        bus.gnt_b      = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.busy       = (state_q != ST_IDLE);
        bus.burst_done = (state_q == ST_DONE);
        bus.aborted    = (state_q == ST_DONE) & aborted_q;
        if (state_q == ST_BURST) begin
            bus.gnt_a    = ~owner_q;
            bus.gnt_b    = owner_q;
            bus.mem_en   = 1'b1;
            bus.mem_we   = we_q;
            bus.mem_addr = base_q + ADDR_W'(beat_q);
            if (we_q) begin
                bus.mem_wdata = owner_q ? bus.wdata_b : bus.wdata_a;
            end
        end
    end

endmodule
`default_nettype wire
